// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU with a valid/ready handshake on both sides.
//
// Single-cycle ops (add/sub, logic, LUI, set-less-than) finish one cycle after
// acceptance. Shifts move one bit per cycle, so a shift by n takes n+1 cycles.
// An optional iterative shift-add multiplier (MULU, aluc 1001) is built only
// when the macro ALU_MC_MULU_EN is defined. Without the macro, aluc 1001 is a
// second LUI encoding and no multiplier logic exists.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand set present            in_ready   block idle, can accept
//   a, b       operands (a[SHW-1:0] = shift amount for shifts)
//   aluc       4-bit operation code
//   out_valid  result and flags present        out_ready  consumer takes result
//   r          result
//   zero, carry, negative, overflow   status flags
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [SHW:0] ONE = {{SHW{1'b0}}, 1'b1};
`ifdef ALU_MC_MULU_EN
    localparam logic [SHW:0] MUL_STEPS = (SHW + 1)'(WIDTH);
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [SHW:0]     cnt;
    logic             is_iter;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] alu_r;
    logic             alu_z;
    logic             alu_c;
    logic             alu_v;

    logic [WIDTH-1:0] step_acc;
    logic             step_bit;
    logic             fin_carry;

`ifdef ALU_MC_MULU_EN
    logic [WIDTH-1:0] mhi;
    logic [WIDTH-1:0] mhi_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH:0]   mul_sum;
`endif

    // Decide whether the incoming op needs the BUSY state. A shift by zero has
    // nothing to iterate over, so it completes like a single-cycle op.
    always_comb begin
        is_iter = (aluc[3:2] == 2'b11) && (a[SHW-1:0] != '0);
`ifdef ALU_MC_MULU_EN
        if (aluc == 4'b1001) begin
            is_iter = 1'b1;
        end
`endif
    end

    // Single-cycle result path, evaluated straight from the live inputs and
    // latched on the acceptance edge. Shift codes land here only for n=0,
    // where the result is b unchanged with no bit shifted out.
    always_comb begin
        sum_ext = '0;
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (aluc)
            4'b0000: begin
                sum_ext = {1'b0, a} + {1'b0, b};
                alu_r   = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
            end
            4'b0001: begin
                alu_r = a - b;
                alu_c = (a < b);
            end
            4'b0010: begin
                alu_r = a + b;
                alu_v = (a[MSB] == b[MSB]) && (alu_r[MSB] != a[MSB]);
            end
            4'b0011: begin
                alu_r = a - b;
                alu_v = (a[MSB] != b[MSB]) && (alu_r[MSB] != a[MSB]);
            end
            4'b0100: alu_r = a & b;
            4'b0101: alu_r = a | b;
            4'b0110: alu_r = a ^ b;
            4'b0111: alu_r = ~(a | b);
            4'b1010: alu_r = {{(WIDTH-1){1'b0}}, (a < b)};
            4'b1011: alu_r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1100, 4'b1101, 4'b1110, 4'b1111: alu_r = b;
            default: alu_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
        endcase
        // The set-less-than ops report operand equality on zero, not r==0.
        alu_z = (aluc[3:1] == 3'b101) ? (a == b) : (alu_r == '0);
    end

    // One iteration of the in-flight op: a single-bit shift, or one
    // shift-add step of the multiplier. fin_carry is the carry to publish
    // if this is the last iteration.
    always_comb begin
        step_acc = acc;
        step_bit = 1'b0;
`ifdef ALU_MC_MULU_EN
        mhi_nxt = mhi;
        mul_sum = '0;
`endif
        case (op_q)
            4'b1100: begin
                step_acc = {acc[MSB], acc[MSB:1]};
                step_bit = acc[0];
            end
            4'b1101: begin
                step_acc = {1'b0, acc[MSB:1]};
                step_bit = acc[0];
            end
            4'b1110, 4'b1111: begin
                step_acc = {acc[MSB-1:0], 1'b0};
                step_bit = acc[MSB];
            end
`ifdef ALU_MC_MULU_EN
            4'b1001: begin
                mul_sum  = {1'b0, mhi} + (acc[0] ? {1'b0, a_q} : '0);
                mhi_nxt  = mul_sum[WIDTH:1];
                step_acc = {mul_sum[0], acc[MSB:1]};
            end
`endif
            default: ;
        endcase
        fin_carry = step_bit;
`ifdef ALU_MC_MULU_EN
        if (op_q == 4'b1001) begin
            fin_carry = (mhi_nxt != '0);
        end
`endif
    end

    // FSM state register; reset drops straight back to IDLE without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs. BUSY leaves on the cycle that performs
    // the final iteration, so a shift by n spends exactly n cycles in BUSY.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = is_iter ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (cnt == ONE) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath. Operands are copied only on acceptance, so input changes while
    // busy cannot disturb the op. r and every flag are rewritten together when
    // an op completes, so nothing leaks over from the previous op, and they
    // are left untouched in DONE so the result stays stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            acc      <= '0;
            cnt      <= '0;
            r        <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
`ifdef ALU_MC_MULU_EN
            mhi      <= '0;
            a_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= aluc;
                        acc  <= b;
                        cnt  <= {1'b0, a[SHW-1:0]};
`ifdef ALU_MC_MULU_EN
                        mhi  <= '0;
                        a_q  <= a;
                        if (aluc == 4'b1001) begin
                            cnt <= MUL_STEPS;
                        end
`endif
                        if (!is_iter) begin
                            r        <= alu_r;
                            zero     <= alu_z;
                            carry    <= alu_c;
                            negative <= alu_r[MSB];
                            overflow <= alu_v;
                        end
                    end
                end
                BUSY: begin
                    acc <= step_acc;
                    cnt <= cnt - ONE;
`ifdef ALU_MC_MULU_EN
                    mhi <= mhi_nxt;
`endif
                    if (cnt == ONE) begin
                        r        <= step_acc;
                        zero     <= (step_acc == '0);
                        carry    <= fin_carry;
                        negative <= step_acc[MSB];
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc -- scoreboard bench for alu_mc (WIDTH=32).
//
// The stimulus process issues directed operations and pushes the
// hand-computed result, flags and latency into a queue. A monitor on the
// falling edge pops and compares whenever a result handshake takes place,
// and reports any result that appears with nothing expected.
// Honours ALU_MC_MULU_EN to pick the expected behaviour of aluc 1001.
// ---------------------------------------------------------------------------
module tb_alu_mc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] r;
    logic        zero;
    logic        carry;
    logic        negative;
    logic        overflow;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int compared;
    int mismatched;
    int cyc;
    int first_valid;
    bit seen_valid;

    alu_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .aluc      (aluc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .zero      (zero),
        .carry     (carry),
        .negative  (negative),
        .overflow  (overflow)
    );

    // Free-running clock and a cycle counter used to measure latency.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Single comparison point shared by the monitor and the stimulus process.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one operand set. Called #1 after a rising edge; returns #1 after
    // the acceptance edge with inputs scrambled to show they are not reused.
    task automatic applyStimulus(input string name, input logic [3:0] op,
                                 input logic [31:0] va, input logic [31:0] vb,
                                 input logic [31:0] er, input logic [3:0] ef,
                                 input int elat, input bit push);
        exp_t e;
        int   guard;
        aluc     = op;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard = guard + 1;
        end
        @(posedge clk);
        #1;
        if (push) begin
            e.r    = er;
            e.f    = ef;
            e.lat  = elat;
            e.acc  = cyc - 1;
            e.name = name;
            sb.push_back(e);
        end
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        aluc     = 4'($urandom);
    endtask

    // Bounded wait for the monitor to drain the scoreboard.
    task automatic waitDone(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard = guard + 1;
        end
        if (sb.size() != 0) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s_timeout: got no result, expected one within 200 cycles", name);
            sb.delete();
        end
    endtask

    // Monitor: records when out_valid first rises and compares at handshake.
    always @(negedge clk) begin
        if (rst) begin
            seen_valid = 1'b0;
        end else if (out_valid) begin
            if (!seen_valid) begin
                seen_valid  = 1'b1;
                first_valid = cyc;
            end
            if (out_ready) begin
                seen_valid = 1'b0;
                if (sb.size() == 0) begin
                    compared   = compared + 1;
                    mismatched = mismatched + 1;
                    $display("[TB] FAIL stale_result: got r=%0h, expected no result", r);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput({mon_e.name, "_r"}, 64'(r), 64'(mon_e.r));
                    checkOutput({mon_e.name, "_flags"}, 64'({zero, carry, negative, overflow}), 64'(mon_e.f));
                    checkOutput({mon_e.name, "_lat"}, 64'(first_valid - mon_e.acc), 64'(mon_e.lat));
                end
            end
        end
    end

    // Overall time limit so a wedged DUT cannot hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence. Flags are written as {zero, carry, negative, overflow}.
    initial begin
        int vcount;
        compared   = 0;
        mismatched = 0;
        seen_valid = 1'b0;
        first_valid = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = '0;
        b          = '0;
        aluc       = '0;
        #1;
        checkOutput("reset_state", 64'({in_ready, out_valid, r, zero, carry, negative, overflow}),
                    64'({1'b1, 1'b0, 32'h0, 4'b0000}));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011, 1, 1'b1);
        waitDone("add_ovf");
        applyStimulus("subu",     4'b0001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0110, 1, 1'b1);
        waitDone("subu");
        applyStimulus("slt_neg",  4'b1011, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1, 1'b1);
        waitDone("slt_neg");
        applyStimulus("sra4",     4'b1100, 32'h00000004, 32'h80000010, 32'hF8000001, 4'b0010, 5, 1'b1);
        waitDone("sra4");
        applyStimulus("sra0",     4'b1100, 32'h00000000, 32'h80000010, 32'h80000010, 4'b0010, 1, 1'b1);
        waitDone("sra0");
        applyStimulus("addu_cy",  4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100, 1, 1'b1);
        waitDone("addu_cy");
        applyStimulus("sub_ovf",  4'b0011, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 1, 1'b1);
        waitDone("sub_ovf");
        applyStimulus("and",      4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010, 1, 1'b1);
        waitDone("and");
        applyStimulus("or",       4'b0101, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1, 1'b1);
        waitDone("or");
        applyStimulus("xor",      4'b0110, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 4'b0000, 1, 1'b1);
        waitDone("xor");
        applyStimulus("nor_ones", 4'b0111, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0010, 1, 1'b1);
        waitDone("nor_ones");
        applyStimulus("nor_zero", 4'b0111, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 4'b1000, 1, 1'b1);
        waitDone("nor_zero");
        applyStimulus("lui",      4'b1000, 32'h5555AAAA, 32'h1234ABCD, 32'hABCD0000, 4'b0010, 1, 1'b1);
        waitDone("lui");
        applyStimulus("sltu_eq",  4'b1010, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1000, 1, 1'b1);
        waitDone("sltu_eq");
        applyStimulus("sltu_lt",  4'b1010, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 1, 1'b1);
        waitDone("sltu_lt");
        applyStimulus("slt_eq",   4'b1011, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1000, 1, 1'b1);
        waitDone("slt_eq");
        applyStimulus("slt_min",  4'b1011, 32'h80000000, 32'h00000000, 32'h00000001, 4'b0000, 1, 1'b1);
        waitDone("slt_min");
        applyStimulus("srl4",     4'b1101, 32'h00000024, 32'h8000001F, 32'h08000001, 4'b0100, 5, 1'b1);
        waitDone("srl4");
        applyStimulus("sll1",     4'b1110, 32'h00000001, 32'h80000001, 32'h00000002, 4'b0100, 2, 1'b1);
        waitDone("sll1");
        applyStimulus("sll31",    4'b1111, 32'h0000001F, 32'h00000003, 32'h80000000, 4'b0110, 32, 1'b1);
        waitDone("sll31");
`ifdef ALU_MC_MULU_EN
        applyStimulus("mulu_hi",  4'b1001, 32'h00010000, 32'h00010000, 32'h00000000, 4'b1100, 33, 1'b1);
        waitDone("mulu_hi");
        applyStimulus("mulu_lo",  4'b1001, 32'h00000007, 32'h00000006, 32'h0000002A, 4'b0000, 33, 1'b1);
        waitDone("mulu_lo");
`else
        applyStimulus("lui_alt",  4'b1001, 32'h00010000, 32'h00010000, 32'h00000000, 4'b1000, 1, 1'b1);
        waitDone("lui_alt");
`endif

        // Backpressure: hold the result, offer a new operand set meanwhile.
        out_ready = 1'b0;
        applyStimulus("bp_addu", 4'b0000, 32'h00000001, 32'h00000002, 32'h00000003, 4'b0000, 1, 1'b1);
        for (int i = 0; i < 10 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            aluc     = 4'b0000;
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            #1;
            checkOutput("bp_hold", 64'({in_ready, out_valid, r, zero, carry, negative, overflow}),
                        64'({1'b0, 1'b1, 32'h00000003, 4'b0000}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
        waitDone("bp_addu");

        // Reset two cycles into a long shift: must abandon it immediately.
        applyStimulus("abort_sll", 4'b1110, 32'h0000001F, 32'h00000001, 32'h0, 4'b0000, 0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("abort_busy", 64'({in_ready, out_valid}), 64'({1'b0, 1'b0}));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_async", 64'({in_ready, out_valid, r, zero, carry, negative, overflow}),
                    64'({1'b1, 1'b0, 32'h0, 4'b0000}));
        @(posedge clk);
        #1;
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) vcount = vcount + 1;
        end
        checkOutput("abort_no_result", 64'(vcount), 64'd0);

        applyStimulus("post_rst", 4'b0000, 32'h00000010, 32'h00000020, 32'h00000030, 4'b0000, 1, 1'b1);
        waitDone("post_rst");

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have derived localparam SHW = $clog2(WIDTH), the shift-amount width.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  operand set present.
REQ-006 in_ready  out  1  block can accept an operand set.
REQ-007 a, b  in  WIDTH each  operands; a[SHW-1:0] is the shift amount for shift ops.
REQ-008 aluc  in  4  operation code.
REQ-009 out_valid  out  1  result and flags present.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 r  out  WIDTH  result.
REQ-012 zero, carry, negative, overflow  out  1 each  status flags.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUSY, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-014 SHALL capture a, b, aluc on the cycle in_valid&in_ready is high; inputs are ignored in all other cycles.
REQ-015 Non-shift ops SHALL go IDLE->DONE with results valid the cycle after acceptance (latency 1).
REQ-016 aluc 0000 ADDU: r=a+b, carry=unsigned carry-out; 0001 SUBU: r=a-b, carry=1 iff a<b unsigned.
REQ-017 aluc 0010 ADD / 0011 SUB: two's-complement, overflow=1 iff signed result overflows WIDTH bits.
REQ-018 aluc 0100 AND, 0101 OR, 0110 XOR, 0111 NOR: bitwise.
REQ-019 aluc 1000 (and 1001 when REQ-033 macro absent) LUI: r = b[WIDTH/2-1:0] shifted left by WIDTH/2, low half zero.
REQ-020 aluc 1010 SLTU: r=1 iff a<b unsigned, else 0; 1011 SLT: same, signed; for both, zero=1 iff a==b.
REQ-021 aluc 1100 SRA, 1101 SRL, 1110/1111 SLL: operand b shifted by n=a[SHW-1:0]; upper bits of a ignored.
REQ-022 Shifts SHALL be iterative, one bit per cycle in BUSY; n=0 goes directly to DONE with r=b, carry=0; n>0 spends n cycles in BUSY, out_valid asserted n+1 cycles after acceptance.
REQ-023 Shift carry SHALL equal the last bit shifted out (bit 0 for SRA/SRL, bit WIDTH-1 for SLL).
REQ-024 carry/overflow SHALL be 0 for any op that does not define them above; flags never retain values from a prior op.
REQ-025 zero SHALL be (r==0) and negative SHALL be r[WIDTH-1], except zero per REQ-020.
REQ-026 In DONE, r and flags SHALL be stable until out_valid&out_ready, then FSM returns to IDLE next cycle; out_ready while out_valid=0 has no effect.
REQ-027 No overlap: a new operand set is accepted no earlier than the cycle after the result handshake.
REQ-028 aluc, a, b changing while BUSY/DONE SHALL not affect the in-flight result.

Reset
REQ-029 rst high SHALL immediately force IDLE, in_ready=1, out_valid=0, r=0, all flags 0, regardless of clk.
REQ-030 rst mid-operation (BUSY or DONE) SHALL abandon the operation; no result is ever presented for it.
REQ-031 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-032 Macro ALU_MC_MULU_EN selects the optional multiplier.
REQ-033 Defined: aluc 1001 SHALL be MULU, iterative shift-add, WIDTH cycles in BUSY, r = low WIDTH bits of unsigned a*b, carry=1 iff high WIDTH bits nonzero, overflow=0; out_valid WIDTH+1 cycles after acceptance.
REQ-034 Undefined: aluc 1001 SHALL behave as LUI (REQ-019) and no multiplier logic exists.

Verification (WIDTH=32)
REQ-035 ADD a=7FFFFFFF, b=1 -> one cycle later r=80000000, overflow=1, negative=1, carry=0, zero=0.
REQ-036 SUBU a=3, b=5 -> r=FFFFFFFE, carry=1; SLT a=FFFFFFFF, b=1 -> r=1, zero=0.
REQ-037 SRA a=4, b=80000010 -> out_valid exactly 5 cycles after acceptance, r=F8000001, carry=0; a=0 -> r=b in 1 cycle.
REQ-038 Backpressure: ADDU result held with out_ready=0 for 10 cycles -> r/flags stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-039 rst asserted 2 cycles into SLL a=31 -> out_valid=0, in_ready=1 asynchronously, no stale result after release.
REQ-040 ALU_MC_MULU_EN defined: aluc 1001 a=00010000, b=00010000 -> after 33 cycles r=0, carry=1, zero=1; undefined: same stimulus -> r=00000000 LUI, 1 cycle.
